// File: rtl/dot_mac_pipe.sv
// dot_mac_pipe: three-stage signed dot-product engine with valid/ready flow
// control. The result is y = sum_k a[k]*b[k] + e, plus the previous y when the
// beat's accumulate flag is set.
//
// Optional feature: define DOT_SAT_EN to saturate the OW-bit result instead of
// wrapping it. Without the macro, no saturation logic is generated.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat
//   in_acc     add this beat's result to the previous result
//   a, b       N packed signed W-bit operands (term k at [k*W +: W])
//   e          signed W-bit addend
//   out_valid  result valid
//   out_ready  sink accepts result
//   y          signed OW-bit result
module dot_mac_pipe #(
    parameter int W  = 16,
    parameter int N  = 2,
    parameter int OW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_acc,
    input  logic [N*W-1:0]  a,
    input  logic [N*W-1:0]  b,
    input  logic [W-1:0]    e,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   y
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + $clog2(N + 1) + 1;
    // One guard bit above the wider of sum and result, so that adding the
    // previous y can never overflow before the final reduction.
    localparam int AW = ((SW > OW) ? SW : OW) + 1;

    logic                 en;
    logic                 v1;
    logic                 v2;
    logic                 v3;
    logic                 acc1;
    logic                 acc2;
    logic signed [PW-1:0] prod_c [N];
    logic signed [PW-1:0] prod1  [N];
    logic signed [SW-1:0] e1;
    logic signed [SW-1:0] tree_c;
    logic signed [SW-1:0] sum2;
    logic signed [AW-1:0] full_c;
    logic        [OW-1:0] y_c;

    // The whole pipeline advances together; a bubble moves like data.
    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod_c[k] = PW'($signed(a[k*W +: W]))
                      * PW'($signed(b[k*W +: W]));
        end
    end

    always_comb begin
        tree_c = e1;
        for (int k = 0; k < N; k++) begin
            tree_c = tree_c + SW'(prod1[k]);
        end
    end

    always_comb begin
        full_c = AW'(sum2);
        if (acc2) begin
            full_c = full_c + AW'($signed(y));
        end
    end

`ifdef DOT_SAT_EN
    localparam logic [OW-1:0] YMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] YMIN = {1'b1, {(OW-1){1'b0}}};

    always_comb begin
        y_c = full_c[OW-1:0];
        if (full_c > AW'($signed(YMAX))) begin
            y_c = YMAX;
        end else if (full_c < AW'($signed(YMIN))) begin
            y_c = YMIN;
        end
    end
`else
    assign y_c = OW'(full_c);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            acc1 <= 1'b0;
            acc2 <= 1'b0;
            e1   <= '0;
            sum2 <= '0;
            y    <= '0;
            for (int k = 0; k < N; k++) begin
                prod1[k] <= '0;
            end
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                for (int k = 0; k < N; k++) begin
                    prod1[k] <= prod_c[k];
                end
                e1   <= SW'($signed(e));
                acc1 <= in_acc;
            end
            if (v1) begin
                sum2 <= tree_c;
                acc2 <= acc1;
            end
            // y doubles as the accumulator: it keeps the last loaded
            // result whether or not the sink has taken it.
            if (v2) begin
                y <= y_c;
            end
        end
    end

endmodule

// File: tb/tb_dot_mac_pipe.sv
// tb_dot_mac_pipe: directed and randomized checks of dot_mac_pipe against a
// behavioural model (queue of expected results, plain integer arithmetic).
module tb_dot_mac_pipe;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int OW = 32;
    localparam longint YMAX = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint YMIN = -YMAX - 1;

    logic           tb_clk    = 1'b0;
    logic           tb_rst    = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic           in_acc    = 1'b0;
    logic [N*W-1:0] a         = '0;
    logic [N*W-1:0] b         = '0;
    logic [W-1:0]   e         = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [OW-1:0]  y;

    int     checks   = 0;
    int     failures = 0;
    int     n_out    = 0;
    longint acc_prev = 0;
    longint exp_q[$];
    longint got_q[$];

    dot_mac_pipe #(
        .W (W),
        .N (N),
        .OW(OW)
    ) u_dut (
        .clk      (tb_clk),
        .rst      (tb_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_acc   (in_acc),
        .a        (a),
        .b        (b),
        .e        (e),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic longint reduce(input longint v);
`ifdef DOT_SAT_EN
        if (v > YMAX) return YMAX;
        if (v < YMIN) return YMIN;
        return v;
`else
        logic [OW-1:0] t;
        t = v[OW-1:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic longint raw_sum();
        longint s;
        s = longint'($signed(e));
        for (int k = 0; k < N; k++) begin
            s += longint'($signed(a[k*W +: W]))
               * longint'($signed(b[k*W +: W]));
        end
        return s;
    endfunction

    // Model and compare process: inputs change just after posedge, so the
    // values seen here are the ones the next edge will act on.
    always @(negedge tb_clk) begin
        longint ex;
        longint s;
        if (tb_rst) begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    ex = exp_q.pop_front();
                    check("y_vs_model", $signed(y), ex);
                end
                got_q.push_back($signed(y));
                n_out++;
            end
            if (in_valid && in_ready) begin
                s = raw_sum();
                if (in_acc) s += acc_prev;
                acc_prev = reduce(s);
                exp_q.push_back(acc_prev);
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic set_ops(input int a0, input int a1, input int b0,
                           input int b1, input int ee, input logic acc);
        a = '0;
        b = '0;
        a[0 +: W] = W'(a0);
        a[W +: W] = W'(a1);
        b[0 +: W] = W'(b0);
        b[W +: W] = W'(b1);
        e = W'(ee);
        in_acc = acc;
    endtask

    task automatic send(input int s, input logic acc);
        set_ops(s, 0, 1, 0, 0, acc);
    endtask

    task automatic wait_got(input int n, input string name);
        for (int i = 0; i < 50 && got_q.size() < n; i++) tick();
        check(name, got_q.size(), n);
    endtask

    int lat;
    int sent;
    int n0;

    initial begin
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", $signed(y), 0);
        check("rst_in_ready", in_ready, 1);
        tb_rst = 1'b1;
        tick();

        // 1: basic sum and latency
        out_ready = 1'b1;
        set_ops(3, -4, 5, 6, 7, 1'b0);
        in_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            tick();
            lat++;
            in_valid = 1'b0;
        end
        check("t1_latency", lat, 3);
        check("t1_y", $signed(y), -2);
        tick();

        // 2: wrap versus saturate
        got_q.delete();
        set_ops(-32768, -32768, -32768, -32768, 32767, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_got(1, "t2_count");
`ifdef DOT_SAT_EN
        check("t2_y", got_q[0], 2147483647);
`else
        check("t2_y", got_q[0], -2147450881);
`endif
        repeat (3) tick();

        // 3: backpressure
        for (int s = 1; s <= 3; s++) begin
            send(s, 1'b0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("t3_in_ready", in_ready, 0);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_y", $signed(y), 1);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_drain_valid", out_valid, 1);
            check("t3_drain_y", $signed(y), i + 1);
            tick();
        end
        #1;
        check("t3_empty", out_valid, 0);

        // 4: accumulate
        got_q.delete();
        send(10, 1'b0);
        in_valid = 1'b1;
        tick();
        send(5, 1'b1);
        tick();
        send(7, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_got(3, "t4_count");
        check("t4_y0", got_q[0], 10);
        check("t4_y1", got_q[1], 15);
        check("t4_y2", got_q[2], 7);
        repeat (3) tick();

        // 5: reset mid-operation
        got_q.delete();
        out_ready = 1'b0;
        send(20, 1'b0);
        in_valid = 1'b1;
        tick();
        send(30, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_y", $signed(y), 20);
        #2;
        tb_rst = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_y", $signed(y), 0);
        exp_q.delete();
        acc_prev = 0;
        tick();
        tb_rst = 1'b1;
        out_ready = 1'b1;
        send(4, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_got(1, "t5_count");
        check("t5_y", got_q[0], 4);
        repeat (3) tick();

        // 6: random stress
        void'($urandom(12345));
        n0 = n_out;
        sent = 0;
        for (int cyc = 0; cyc < 5000 && sent < 200; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            e = W'($urandom());
            in_acc = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (n_out - n0) < 200; i++) tick();
        repeat (5) tick();
        check("t6_sent", sent, 200);
        check("t6_count", n_out - n0, 200);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_mac_pipe.md
Name: dot_mac_pipe

Overview:
- Parametrised, fully pipelined signed dot-product engine: y = sum over k of (a[k]*b[k]), plus e.
- Successor to the two-term pipelined MAC (y = a*b + c*d + e). Generalised to N product terms and width W.
- Adds full valid/ready backpressure, one beat per cycle throughput, and a per-beat accumulate mode.
- Sits between an operand source and a result sink, both using valid/ready handshakes.

Parameters:
- W, 16: width of each signed operand a[k], b[k] and of e.
- N, 2: number of product terms, 1..8.
- OW, 32: width of signed result y. The full-precision sum is reduced to OW bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_acc  input  1  beat flag: add this result to the previous result.
- a  input  N*W  packed signed operands; term k is a[k*W +: W].
- b  input  N*W  packed signed operands; term k is b[k*W +: W].
- e  input  W  signed addend.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- y  output  OW  signed result.

Behaviour:
- Reset: any cycle with rst=0, asynchronously:
  - all stage valid bits = 0, so out_valid=0;
  - y=0;
  - accumulator register = 0;
  - all data registers = 0.
  - In-flight beats are discarded. Operation resumes on the first clock edge after rst returns to 1.
- Pipeline is three stages:
  - S1 registers the N products (2W bits each, signed), e sign-extended, and in_acc.
  - S2 registers the adder-tree sum. Its internal width is 2W + clog2(N+1) + 1, with no loss.
  - S3 is the output register y. On a beat, S3 holds either (S2 sum) or (previous S3 value + S2 sum), selected by the carried acc flag. The result is reduced to OW bits.
- Arithmetic:
  - All operands are two's complement.
  - Reduction to OW is a wrap (truncate low OW bits) unless DOT_SAT_EN is defined.
  - Accumulation adds the stored OW-bit previous y, sign-extended, before the reduction.
- Accumulator:
  - The previous result is the value most recently loaded into S3, whether or not it has been consumed yet.
  - in_acc=1 on the first beat after reset accumulates onto 0.
- Handshake:
  - Global advance enable: en = !out_valid || out_ready.
  - in_ready = en, a combinational function of out_valid and out_ready.
  - A beat is accepted when in_valid && in_ready.
  - When en=1, every stage shifts by one. Bubbles (valid=0) shift like data and are not collapsed.
  - When en=0, all stages hold: y and out_valid stay stable until consumed.
- Latency and throughput:
  - An accepted beat appears on out_valid exactly 3 cycles later, provided en=1 throughout.
  - Each cycle with en=0 adds one cycle of latency.
  - Throughput is 1 beat per cycle while out_ready=1.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.
- Simultaneous events:
  - Output consumed and new beat accepted in the same cycle is legal; no bubble is inserted.
  - in_valid=0 with en=1 inserts a bubble.
- Operands and in_acc are sampled only on accept. Inputs are don't-care when in_valid=0.

Optional Feature:
- Macro: DOT_SAT_EN.
- Defined: reduction to OW saturates.
  - Values above 2^(OW-1)-1 give 2^(OW-1)-1.
  - Values below -2^(OW-1) give -2^(OW-1).
  - The accumulator stores the saturated value.
- Not defined: plain wrap to OW bits. No saturation logic is generated.

Test Plan:
1. Basic term sum, W=16, N=2, OW=32: a={3,-4}, b={5,6}, e=7, in_acc=0 → y=-2. out_valid rises 3 cycles after accept with out_ready=1.
2. Wrap versus saturate: a={-32768,-32768}, b={-32768,-32768}, e=32767 → y=-2147450881 without DOT_SAT_EN; y=2147483647 with DOT_SAT_EN.
3. Backpressure:
   - Stimulus: accept 3 beats back to back (sums 1, 2, 3), then hold out_ready=0 for 5 cycles.
   - Required: in_ready=0 while out_valid=1; y holds at 1 throughout.
   - Then set out_ready=1: results 1, 2, 3 arrive on consecutive cycles.
4. Accumulate: beats with sums 10 (in_acc=0), 5 (in_acc=1), 7 (in_acc=0) → y = 10, 15, 7.
5. Reset mid-operation:
   - Stimulus: 2 beats in flight, then rst=0 for 1 cycle.
   - Required: out_valid=0 and y=0 immediately, without waiting for a clock edge.
   - After release, a beat with sum 4 and in_acc=1 → y=4.
6. Random stress: 200 seeded random vectors (seed 12345), N=4, random in_valid and out_ready, random in_acc. Required: every result matches the reference model, in order, and the count is exactly 200.
